// File: rtl/tone_div_arbiter.sv
// tone_div_arbiter: round-robin front end sharing one fixed-latency pipelined
// signed divider between N_REQ requesters. A tag pipeline that runs parallel to
// the divider routes each quotient back to its requester. A saturated result is
// substituted whenever the divisor is zero.
module tone_div_arbiter #(
    parameter int N_REQ       = 3,
    parameter int DW          = 32,
    parameter int QW          = 64,
    parameter int DIV_LATENCY = 36
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_dividend,
    input  logic [N_REQ*DW-1:0] req_divisor,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [QW-1:0]       rsp_quotient,
    output logic                rsp_dz,
    output logic                div_in_valid,
    output logic [DW-1:0]       div_in_dividend,
    output logic [DW-1:0]       div_in_divisor,
    input  logic                div_out_valid,
    input  logic [QW-1:0]       div_out_data,
    input  logic                flush,
    output logic                flush_done,
    output logic                busy,
    output logic                err_sync
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(DIV_LATENCY + 3);
    localparam logic [QW-1:0] Q_MAX = {1'b0, {(QW-1){1'b1}}};
    localparam logic [QW-1:0] Q_MIN = {1'b1, {(QW-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    typedef struct packed {
        logic          valid;
        logic [PW-1:0] id;
        logic          dz;
        logic          neg;
    } tag_t;

    state_t        state_q;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] grant_id, cand;
    logic          grant_any;
    int unsigned   idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_done_q;

    logic          iss_valid_q;
    logic [PW-1:0] iss_id_q;
    logic          iss_dz_q, iss_neg_q;
    logic [DW-1:0] iss_dividend_q, iss_divisor_q;
    logic [DW-1:0] sel_dividend, sel_divisor;

    tag_t          tag_q [DIV_LATENCY];
    tag_t          head;

    logic [N_REQ-1:0] rsp_valid_q;
    logic [QW-1:0]    rsp_quotient_q;
    logic             rsp_dz_q, err_q, rsp_any;

    // Round-robin grant: first valid requester at or after the pointer, none while draining/flushing
    always_comb begin
        req_ready = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        idx       = 0;
        if (state_q != ST_DRAIN && !flush) begin
            for (int unsigned off = 0; off < N_REQ; off++) begin
                idx = 32'(ptr_q) + off;
                if (idx >= N_REQ) idx = idx - N_REQ;
                cand = PW'(idx);
                if (!grant_any && req_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_id  = cand;
                end
            end
            if (grant_any) req_ready[grant_id] = 1'b1;
        end
        ptr_d = ptr_q;
        if (grant_any) ptr_d = (grant_id == PW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    end

    assign sel_dividend = req_dividend[int'(grant_id)*DW +: DW];
    assign sel_divisor  = req_divisor[int'(grant_id)*DW +: DW];
    assign head         = tag_q[DIV_LATENCY-1];
    assign rsp_any      = |rsp_valid_q;

    // Outstanding count: +1 per acceptance, -1 per delivered response
    always_comb begin
        cnt_d = cnt_q;
        if (grant_any && !rsp_any)      cnt_d = cnt_q + 1'b1;
        else if (!grant_any && rsp_any) cnt_d = cnt_q - 1'b1;
    end

    // Control FSM, round-robin pointer, outstanding counter and drain-complete pulse
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            flush_done_q <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            flush_done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (flush) begin
                        // Nothing left in flight: report completion right away
                        if (cnt_d == '0) begin
                            flush_done_q <= 1'b1;
                            state_q      <= ST_IDLE;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end else if (|req_valid) begin
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_d == '0) begin
                        flush_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Register the accepted operands and their tag for the divider input stage
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            iss_valid_q    <= 1'b0;
            iss_id_q       <= '0;
            iss_dz_q       <= 1'b0;
            iss_neg_q      <= 1'b0;
            iss_dividend_q <= '0;
            iss_divisor_q  <= '0;
        end else begin
            iss_valid_q <= grant_any;
            if (grant_any) begin
                iss_id_q       <= grant_id;
                iss_dz_q       <= (sel_divisor == '0);
                iss_neg_q      <= sel_dividend[DW-1];
                iss_dividend_q <= sel_dividend;
                iss_divisor_q  <= sel_divisor;
            end
        end
    end

    // Tag pipeline shadowing the divider, head aligned with div_out_valid
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int unsigned k = 0; k < DIV_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= {iss_valid_q, iss_id_q, iss_dz_q, iss_neg_q};
            for (int unsigned k = 1; k < DIV_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // Response register driven by the head tag; sticky flag on divider/tag disagreement
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rsp_valid_q    <= '0;
            rsp_quotient_q <= '0;
            rsp_dz_q       <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            rsp_valid_q <= '0;
            rsp_dz_q    <= 1'b0;
            if (head.valid) begin
                rsp_valid_q[head.id] <= 1'b1;
                rsp_dz_q             <= head.dz;
                if (head.dz) rsp_quotient_q <= head.neg ? Q_MIN : Q_MAX;
                else         rsp_quotient_q <= div_out_data;
            end
            if (div_out_valid != head.valid) err_q <= 1'b1;
        end
    end

    assign div_in_valid    = iss_valid_q;
    assign div_in_dividend = iss_dividend_q;
    assign div_in_divisor  = iss_divisor_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_quotient    = rsp_quotient_q;
    assign rsp_dz          = rsp_dz_q;
    assign flush_done      = flush_done_q;
    assign busy            = (cnt_q != '0);
    assign err_sync        = err_q;

endmodule

// File: tb/tb_tone_div_arbiter.sv
// Directed bench for tone_div_arbiter with a behavioural pipelined divider.
module tb_tone_div_arbiter;

    localparam int NR = 3;
    localparam int DW = 32;
    localparam int QW = 64;
    localparam int L  = 6;

    localparam logic [63:0] MINQ = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXQ = 64'h7FFF_FFFF_FFFF_FFFF;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*DW-1:0] req_dividend = '0;
    logic [NR*DW-1:0] req_divisor = '0;
    logic [NR-1:0]    req_ready;
    logic [NR-1:0]    rsp_valid;
    logic [QW-1:0]    rsp_quotient;
    logic             rsp_dz;
    logic             div_in_valid;
    logic [DW-1:0]    div_in_dividend;
    logic [DW-1:0]    div_in_divisor;
    logic             div_out_valid;
    logic [QW-1:0]    div_out_data;
    logic             flush = 1'b0;
    logic             flush_done;
    logic             busy;
    logic             err_sync;
    logic             inj = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [2:0]  g_exp [6];
    logic [2:0]  r_exp [6];
    logic [63:0] q_exp [6];
    logic [2:0]  g6_exp [5];

    always #5 clk_in = ~clk_in;

    tone_div_arbiter #(
        .N_REQ       (NR),
        .DW          (DW),
        .QW          (QW),
        .DIV_LATENCY (L)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .req_valid       (req_valid),
        .req_dividend    (req_dividend),
        .req_divisor     (req_divisor),
        .req_ready       (req_ready),
        .rsp_valid       (rsp_valid),
        .rsp_quotient    (rsp_quotient),
        .rsp_dz          (rsp_dz),
        .div_in_valid    (div_in_valid),
        .div_in_dividend (div_in_dividend),
        .div_in_divisor  (div_in_divisor),
        .div_out_valid   (div_out_valid),
        .div_out_data    (div_out_data),
        .flush           (flush),
        .flush_done      (flush_done),
        .busy            (busy),
        .err_sync        (err_sync)
    );

    // Behavioural divider: L-cycle pipeline, junk output on zero divisor
    logic [L-1:0] m_v = '0;
    logic [63:0]  m_q [L];

    function automatic logic [63:0] divq(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (b == '0) return 64'hDEAD_BEEF;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa / sb;
    endfunction

    always @(posedge clk_in) begin
        m_v    <= {m_v[L-2:0], div_in_valid};
        m_q[0] <= divq(div_in_dividend, div_in_divisor);
        for (int i = 1; i < L; i++) m_q[i] <= m_q[i-1];
    end

    assign div_out_valid = m_v[L-1] | inj;
    assign div_out_data  = m_q[L-1];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] dd, input logic [31:0] ds);
        req_dividend[i*DW +: DW] = dd;
        req_divisor[i*DW +: DW]  = ds;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        g_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        r_exp  = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        q_exp  = '{64'd20, -64'sd12, 64'd9, 64'd20, -64'sd12, 64'd9};
        g6_exp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Reset state
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_in_valid", div_in_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_sync", err_sync, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_req_ready", req_ready, 0);
        repeat (2) @(posedge clk_in);
        #3 rst_in = 1'b0;

        // Single request: 100/4 from requester 0
        tick();
        set_req(0, 32'd100, 32'd4);
        req_valid = 3'b001;
        #1 chk("single_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("single_div_in_valid", div_in_valid, 1);
        chk("single_div_dividend", div_in_dividend, 100);
        chk("single_div_divisor", div_in_divisor, 4);
        chk("single_busy", busy, 1);
        repeat (6) tick();
        chk("single_rsp_early", rsp_valid, 0);
        tick();
        chk("single_rsp_valid", rsp_valid, 3'b001);
        chk("single_quotient", rsp_quotient, 25);
        chk("single_dz", rsp_dz, 0);
        tick();
        chk("single_rsp_gone", rsp_valid, 0);
        chk("single_busy_idle", busy, 0);

        // Move pointer to 0 with a lone request on 2, then full contention
        tick();
        set_req(2, 32'd9, 32'd3);
        req_valid = 3'b100;
        #1 chk("rr_pre_ready", req_ready, 3'b100);
        tick();
        set_req(0, 32'd60, 32'd3);
        set_req(1, -32'sd60, 32'd5);
        set_req(2, 32'd63, 32'd7);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1 chk("rr_grant", req_ready, g_exp[k]);
            tick();
        end
        req_valid = '0;
        tick();
        chk("rr_pre_rsp", rsp_valid, 3'b100);
        chk("rr_pre_q", rsp_quotient, 3);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_rsp", rsp_valid, r_exp[k]);
            chk("rr_q", rsp_quotient, q_exp[k]);
        end
        tick();
        chk("rr_rsp_done", rsp_valid, 0);

        // Divide-by-zero: -7/0 then 5/0 from requester 1
        tick();
        set_req(1, -32'sd7, 32'd0);
        req_valid = 3'b010;
        #1 chk("dz_ready0", req_ready, 3'b010);
        tick();
        set_req(1, 32'd5, 32'd0);
        #1 chk("dz_ready1", req_ready, 3'b010);
        chk("dz_issued", div_in_valid, 1);
        chk("dz_issued_divisor", div_in_divisor, 0);
        tick();
        req_valid = '0;
        repeat (6) tick();
        chk("dz_rsp0", rsp_valid, 3'b010);
        chk("dz_q0", rsp_quotient, MINQ);
        chk("dz_flag0", rsp_dz, 1);
        tick();
        chk("dz_rsp1", rsp_valid, 3'b010);
        chk("dz_q1", rsp_quotient, MAXQ);
        chk("dz_flag1", rsp_dz, 1);
        tick();
        chk("dz_rsp_done", rsp_valid, 0);
        chk("dz_flag_clear", rsp_dz, 0);
        chk("dz_err_sync", err_sync, 0);

        // Flush with two operations in flight and requester 2 waiting
        tick();
        set_req(0, 32'd8, 32'd2);
        set_req(1, -32'sd9, 32'd3);
        req_valid = 3'b011;
        #1 chk("fl_ready0", req_ready, 3'b001);
        tick();
        #1 chk("fl_ready1", req_ready, 3'b010);
        tick();
        set_req(2, 32'd1, 32'd1);
        req_valid = 3'b100;
        flush = 1'b1;
        #1 chk("fl_ready_flush", req_ready, 0);
        tick();
        flush = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1 chk("fl_drain_ready", req_ready, 0);
            chk("fl_drain_done", flush_done, 0);
            tick();
        end
        chk("fl_rsp0", rsp_valid, 3'b001);
        chk("fl_q0", rsp_quotient, 4);
        chk("fl_ready_rsp0", req_ready, 0);
        tick();
        chk("fl_rsp1", rsp_valid, 3'b010);
        chk("fl_q1", rsp_quotient, -64'sd3);
        chk("fl_busy_last", busy, 1);
        chk("fl_done_early", flush_done, 0);
        tick();
        chk("fl_done", flush_done, 1);
        chk("fl_busy_fall", busy, 0);
        chk("fl_rsp_none", rsp_valid, 0);
        chk("fl_ready_after", req_ready, 3'b100);
        req_valid = '0;
        tick();
        chk("fl_done_pulse", flush_done, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_idle_done", flush_done, 1);
        tick();
        chk("fl_idle_done_pulse", flush_done, 0);

        // Sync error: divider valid with an empty tag pipeline
        inj = 1'b1;
        tick();
        inj = 1'b0;
        chk("se_err", err_sync, 1);
        chk("se_no_rsp", rsp_valid, 0);
        set_req(0, 32'd12, 32'd4);
        req_valid = 3'b001;
        #1 chk("se_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        repeat (7) tick();
        chk("se_good_rsp", rsp_valid, 3'b001);
        chk("se_good_q", rsp_quotient, 3);
        chk("se_err_sticky", err_sync, 1);

        // Async reset with five operations outstanding
        tick();
        for (int i = 0; i < NR; i++) set_req(i, 32'd10, 32'd2);
        req_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("ar_grant", req_ready, g6_exp[k]);
            tick();
        end
        req_valid = '0;
        tick();
        chk("ar_busy_before", busy, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("ar_rsp", rsp_valid, 0);
        chk("ar_busy", busy, 0);
        chk("ar_div_in", div_in_valid, 0);
        chk("ar_err", err_sync, 0);
        chk("ar_flush_done", flush_done, 0);
        tick();
        #2 rst_in = 1'b0;
        req_valid = 3'b111;
        #1 chk("ar_ptr_zero", req_ready, 3'b001);
        req_valid = '0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("ar_no_stale_rsp", rsp_valid, 0);
            chk("ar_busy_idle", busy, 0);
        end
        chk("ar_err_stale", err_sync, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tone_div_arbiter.md
Name: tone_div_arbiter

Overview:
- Shares one fixed-latency, fully pipelined signed divider between N_REQ requesters; the default of 3 matches the three per-interval change/level quotients the tone detector computes.
- Arbitrates requests round-robin, drives the divider input and tracks each in-flight operation with a tag pipeline.
- Routes each quotient back to its originator and substitutes a saturated result on divide-by-zero.
- Sits between the tone detection FSM and a single divider instance, replacing one divider per change term.

Parameters:
- N_REQ, 3, number of requesters
- DW, 32, dividend/divisor width (signed)
- QW, 64, divider result width (signed)
- DIV_LATENCY, 36, cycles from divider input valid to output valid; must be >= 1

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_dividend  in  N_REQ*DW  packed dividends; requester i occupies [i*DW +: DW]
- req_divisor  in  N_REQ*DW  packed divisors, same packing as req_dividend
- req_ready  out  N_REQ  one-hot grant; combinational from req_valid, pointer and state
- rsp_valid  out  N_REQ  one-hot, one-cycle result strobe
- rsp_quotient  out  QW  result, valid while any rsp_valid bit is high
- rsp_dz  out  1  the result was a divide-by-zero substitute
- div_in_valid  out  1  divider input valid
- div_in_dividend  out  DW  divider dividend
- div_in_divisor  out  DW  divider divisor
- div_out_valid  in  1  divider output valid
- div_out_data  in  QW  divider output
- flush  in  1  stop granting and drain in-flight operations
- flush_done  out  1  one-cycle pulse when the drain completes
- busy  out  1  outstanding count != 0
- err_sync  out  1  sticky: divider valid disagrees with the tag pipeline

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, round-robin pointer 0, tag pipeline cleared, outstanding 0. Assertion mid-operation discards every in-flight tag; divider outputs arriving after reset release raise err_sync.
- States:
  - IDLE: no request pending. Moves to RUN when any req_valid bit is high and flush=0.
  - RUN: grants one request per cycle.
  - DRAIN: entered from IDLE or RUN when flush=1. No grants. Stays until outstanding==0, then pulses flush_done for one cycle and returns to IDLE. If flush=1 arrives with outstanding==0, flush_done pulses on the next cycle.
- Grant rule: req_ready is 0 in DRAIN and whenever flush=1. Otherwise it grants the first requester with req_valid=1 searching from the pointer upward, wrapping modulo N_REQ. After a grant to requester i the pointer becomes (i+1) mod N_REQ; with no grant the pointer holds. At most one grant per cycle.
- Handshake: a request is accepted on the edge where req_valid[i] and req_ready[i] are both high. The requester holds its data stable until accepted.
- Latency: for acceptance at edge t:
  - div_in_valid with registered operands is driven in cycle t+1;
  - div_out_valid is expected in cycle t+1+DIV_LATENCY;
  - rsp_valid[i] is registered and high in cycle t+2+DIV_LATENCY, for exactly one cycle.
  - Total latency is DIV_LATENCY+2; throughput is 1 per cycle.
- Tag pipeline: DIV_LATENCY stages, each holding {valid, id, dz, dividend_sign}, advanced every cycle. Responses are returned in issue order.
- Divide-by-zero: the operation is still issued, so the pipeline stays aligned. The divider output is ignored and rsp_quotient is forced to {0, all 1s} (max positive) if the dividend is >= 0, else {1, all 0s} (min negative). rsp_dz=1 on that response only.
- Sync check: if div_out_valid differs from the head-of-pipeline tag valid, err_sync is set. It stays set until reset. The response is generated from the tag, never from div_out_valid alone.
- Outstanding counter: +1 on acceptance, -1 on response. Simultaneous accept and response leaves it unchanged. It never exceeds DIV_LATENCY+2.
- Simultaneous flush and req_valid: flush wins and no grant is issued that cycle.

Test Plan:
- Single request: req 0 sends 100/4 → req_ready[0] high that cycle; rsp_valid=3'b001 exactly DIV_LATENCY+2 cycles later; rsp_quotient equals the divider model output; rsp_dz=0.
- Contention: all three valid continuously for 6 cycles from pointer 0 → grants in order 0,1,2,0,1,2; responses in the same order on consecutive cycles.
- Divide-by-zero: req 1 sends -7/0, then 5/0 → the first response is min negative with rsp_dz=1, the second max positive with rsp_dz=1; rsp_valid=3'b010 for both.
- Flush: two requests in flight, then flush=1 with req 2 valid → req_ready stays 0; flush_done pulses one cycle after the last rsp_valid; busy falls in the same cycle.
- Sync error: inject div_out_valid with an empty pipeline → err_sync=1 and no rsp_valid. err_sync stays 1 after subsequent good traffic until rst_in is asserted.
- Async reset mid-flight: assert rst_in between clock edges with 5 outstanding → outputs 0 immediately; after release the pointer is 0, busy=0 and no stale rsp_valid appears.
